// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
//   state_e : 2-bit FSM state encoding (RUN / HOLD / FLUSH / HALT)
//   PC_INC  : sequential fetch increment (one 32-bit instruction)
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [31:0] PC_INC = 32'h4;

endpackage

// File: rtl/pipe_hold_wdog.sv
// Consecutive-stall watchdog.
// Counts back-to-back stalled cycles and flags expiry in the cycle that would
// be the HOLD_MAX-th consecutive stall, so the owner can halt at that edge.
// Ports:
//   clk      in  core clock
//   rst      in  synchronous active-high reset
//   stall_i  in  this cycle is a stalled cycle
//   clr_i    in  clear the count (redirect in progress)
//   expire_o out stall limit reached this cycle (combinational)
// HOLD_MAX = 0 disables the watchdog.
module pipe_hold_wdog #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CW-1:0] LIMIT = (HOLD_MAX > 0) ? CW'(HOLD_MAX - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any non-stalled cycle breaks the run of consecutive stalls.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !stall_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (HOLD_MAX != 0) && stall_i && !clr_i && (cnt_q == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: owns the program counter and drives flush/stall of the
// if_id and id_ex registers from the execute stage's redirect/hold requests and
// fetch back-pressure. Adds BRANCH_BUBBLES fetch bubbles after a redirect,
// halts on a stall watchdog timeout or a misaligned jump target.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   jump_addr_i     redirect target from ex
//   jump_ena_i      redirect request from ex (single cycle)
//   hold_flag_i     ex multi-cycle hold request
//   bus_hold_i      instruction fetch not ready
//   pc_o            fetch address
//   flush_if_id_o   clear if_id at next edge
//   flush_id_ex_o   clear id_ex at next edge
//   stall_o         freeze pc, if_id, id_ex at next edge
//   halted_o        core halted (sticky until rst)
//   timeout_o       halt cause: watchdog (sticky)
//   misalign_o      halt cause: misaligned jump target (sticky)
//   dbg_state_o     current FSM state (debug visibility)
//
// Request semantics: jump_ena_i is a one-cycle pulse acted on at the edge that
// ends the cycle it is high; a jump always wins over a stall in that cycle.
// stall_o is combinational and is the only thing that freezes the pipeline;
// the requester keeps its stall request high for as long as it needs the hold.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
    parameter int unsigned BRANCH_BUBBLES = 1,
    parameter int unsigned HOLD_MAX       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] jump_addr_i,
    input  logic        jump_ena_i,
    input  logic        hold_flag_i,
    input  logic        bus_hold_i,
    output logic [31:0] pc_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        stall_o,
    output logic        halted_o,
    output logic        timeout_o,
    output logic        misalign_o,
    output logic [1:0]  dbg_state_o
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  bub_q, bub_d;
    logic        halted_q, halted_d;
    logic        timeout_q, timeout_d;
    logic        misalign_q, misalign_d;

    logic        stall_req;
    logic        wdog_stall;
    logic        wdog_expire;

    assign stall_req  = hold_flag_i | bus_hold_i;
    // A cycle counts as stalled only when the stall actually takes effect.
    assign wdog_stall = stall_req & ~jump_ena_i & (state_q != ST_HALT);

    pipe_hold_wdog #(
        .HOLD_MAX (HOLD_MAX)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .stall_i  (wdog_stall),
        .clr_i    (jump_ena_i),
        .expire_o (wdog_expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_ADDR;
            bub_q      <= 2'd0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bub_q      <= bub_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic; priority HALT > jump > stall > bubbles/advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bub_d      = bub_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        misalign_d = misalign_q;
        if (state_q != ST_HALT) begin
            if (jump_ena_i) begin
                if (jump_addr_i[1:0] != 2'b00) begin
                    state_d    = ST_HALT;
                    halted_d   = 1'b1;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = jump_addr_i;
                    if (BRANCH_BUBBLES > 0) begin
                        state_d = ST_FLUSH;
                        bub_d   = 2'(BRANCH_BUBBLES);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end else if (stall_req) begin
                if (wdog_expire) begin
                    state_d   = ST_HALT;
                    halted_d  = 1'b1;
                    timeout_d = 1'b1;
                end else if (state_q != ST_FLUSH) begin
                    // A stall inside FLUSH freezes the bubble count in place.
                    state_d = ST_HOLD;
                end
            end else begin
                pc_d = pc_q + PC_INC;
                if (state_q == ST_FLUSH) begin
                    bub_d = bub_q - 2'd1;
                    if (bub_q <= 2'd1) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        stall_o       = 1'b0;
        if (!rst) begin
            if (state_q == ST_HALT) begin
                stall_o       = 1'b1;
                flush_id_ex_o = 1'b1;
            end else begin
                flush_if_id_o = jump_ena_i | (state_q == ST_FLUSH);
                flush_id_ex_o = jump_ena_i;
                stall_o       = stall_req & ~jump_ena_i;
            end
        end
    end

    assign pc_o        = pc_q;
    assign halted_o    = halted_q;
    assign timeout_o   = timeout_q;
    assign misalign_o  = misalign_q;
    assign dbg_state_o = state_q;

endmodule
